// File: rtl/guess_game_ctrl.sv
// Guessing-game controller: holds a secret, presents each guess and the secret
// to an external magnitude comparator, samples its EQ/GT/LT flags one cycle
// later, and reports hints, the attempt count and the WIN/LOSE outcome.
module guess_game_ctrl #(
  parameter int WIDTH     = 4,
  parameter int MAX_TRIES = 5,
  parameter int TRY_W     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_secret,
  input  logic [WIDTH-1:0] secret_in,
  input  logic             guess_valid,
  input  logic [WIDTH-1:0] guess_in,
  output logic             guess_ready,
  output logic [WIDTH-1:0] cmp_a,
  output logic [WIDTH-1:0] cmp_b,
  input  logic             cmp_eq,
  input  logic             cmp_gt,
  input  logic             cmp_lt,
  output logic             result_valid,
  output logic             hint_hi,
  output logic             hint_lo,
  output logic [TRY_W-1:0] tries,
  output logic             win,
  output logic             lose,
  output logic             err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READY   = 3'd1,
    COMPARE = 3'd2,
    WIN     = 3'd3,
    LOSE    = 3'd4
  } state_t;

  localparam logic [TRY_W-1:0] MAX_T = TRY_W'(MAX_TRIES);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cmp_a_q, cmp_a_d;
  logic [WIDTH-1:0] cmp_b_q, cmp_b_d;
  logic [TRY_W-1:0] tries_q, tries_d;
  logic             result_valid_q, result_valid_d;
  logic             hint_hi_q, hint_hi_d;
  logic             hint_lo_q, hint_lo_d;
  logic             win_q, win_d;
  logic             lose_q, lose_d;
  logic             err_q, err_d;

  logic [TRY_W-1:0] tries_inc;
  logic             flags_onehot;

  assign tries_inc    = tries_q + TRY_W'(1);
  assign flags_onehot = ({cmp_eq, cmp_gt, cmp_lt} == 3'b100) ||
                        ({cmp_eq, cmp_gt, cmp_lt} == 3'b010) ||
                        ({cmp_eq, cmp_gt, cmp_lt} == 3'b001);

  // Next-state and registered-output logic; load_secret overrides everything else.
  always_comb begin
    state_d        = state_q;
    cmp_a_d        = cmp_a_q;
    cmp_b_d        = cmp_b_q;
    tries_d        = tries_q;
    result_valid_d = 1'b0;
    hint_hi_d      = hint_hi_q;
    hint_lo_d      = hint_lo_q;
    win_d          = win_q;
    lose_d         = lose_q;
    err_d          = err_q;

    if (load_secret) begin
      // New game from any state; an in-flight compare is discarded.
      cmp_b_d   = secret_in;
      tries_d   = '0;
      hint_hi_d = 1'b0;
      hint_lo_d = 1'b0;
      win_d     = 1'b0;
      lose_d    = 1'b0;
      err_d     = 1'b0;
      state_d   = READY;
    end else begin
      unique case (state_q)
        READY: begin
          if (guess_valid) begin
            cmp_a_d = guess_in;
            state_d = COMPARE;
          end
        end
        COMPARE: begin
          tries_d        = tries_inc;
          result_valid_d = 1'b1;
          if (flags_onehot) begin
            hint_hi_d = cmp_gt;
            hint_lo_d = cmp_lt;
          end else begin
            // Malformed flags: record the fault and treat the guess as a miss.
            err_d     = 1'b1;
            hint_hi_d = 1'b0;
            hint_lo_d = 1'b0;
          end
          if (flags_onehot && cmp_eq) begin
            win_d   = 1'b1;
            state_d = WIN;
          end else if (tries_inc == MAX_T) begin
            lose_d  = 1'b1;
            state_d = LOSE;
          end else begin
            state_d = READY;
          end
        end
        default: ;  // IDLE waits for a secret; WIN/LOSE hold until reloaded
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cmp_a_q        <= '0;
      cmp_b_q        <= '0;
      tries_q        <= '0;
      result_valid_q <= 1'b0;
      hint_hi_q      <= 1'b0;
      hint_lo_q      <= 1'b0;
      win_q          <= 1'b0;
      lose_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      cmp_a_q        <= cmp_a_d;
      cmp_b_q        <= cmp_b_d;
      tries_q        <= tries_d;
      result_valid_q <= result_valid_d;
      hint_hi_q      <= hint_hi_d;
      hint_lo_q      <= hint_lo_d;
      win_q          <= win_d;
      lose_q         <= lose_d;
      err_q          <= err_d;
    end
  end

  assign guess_ready  = (state_q == READY);
  assign cmp_a        = cmp_a_q;
  assign cmp_b        = cmp_b_q;
  assign tries        = tries_q;
  assign result_valid = result_valid_q;
  assign hint_hi      = hint_hi_q;
  assign hint_lo      = hint_lo_q;
  assign win          = win_q;
  assign lose         = lose_q;
  assign err          = err_q;

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Bench for guess_game_ctrl: behavioural comparator on cmp_a/cmp_b, a table of
// directed vectors, and hand-written sequences for error flags and reset/reload.
module tb_guess_game_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_secret;
  logic [3:0] secret_in;
  logic       guess_valid;
  logic [3:0] guess_in;
  logic       guess_ready;
  logic [3:0] cmp_a, cmp_b;
  logic       cmp_eq, cmp_gt, cmp_lt;
  logic       result_valid, hint_hi, hint_lo, win, lose, err;
  logic [2:0] tries;
  logic       force_bad;

  int n_checks = 0;
  int n_fail   = 0;

  guess_game_ctrl #(.WIDTH(4), .MAX_TRIES(5), .TRY_W(3)) dut (
    .clk(clk), .rst(rst), .load_secret(load_secret), .secret_in(secret_in),
    .guess_valid(guess_valid), .guess_in(guess_in), .guess_ready(guess_ready),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_eq(cmp_eq), .cmp_gt(cmp_gt), .cmp_lt(cmp_lt),
    .result_valid(result_valid), .hint_hi(hint_hi), .hint_lo(hint_lo),
    .tries(tries), .win(win), .lose(lose), .err(err)
  );

  // Comparator model; force_bad makes GT and LT both assert.
  assign cmp_eq = force_bad ? 1'b0 : (cmp_a == cmp_b);
  assign cmp_gt = force_bad ? 1'b1 : (cmp_a >  cmp_b);
  assign cmp_lt = force_bad ? 1'b1 : (cmp_a <  cmp_b);

  always #5 clk = ~clk;

  typedef struct {
    int rst, ld, sec, gv, g;
    int rv, hi, lo, tr, w, l, e, rdy;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm, input int idx, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s step%0d: got %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input int rv, input int hi, input int lo,
                           input int tr, input int w, input int l, input int e,
                           input int rdy);
    check("result_valid", idx, int'(result_valid), rv);
    check("hint_hi",      idx, int'(hint_hi),      hi);
    check("hint_lo",      idx, int'(hint_lo),      lo);
    check("tries",        idx, int'(tries),        tr);
    check("win",          idx, int'(win),          w);
    check("lose",         idx, int'(lose),         l);
    check("err",          idx, int'(err),          e);
    check("guess_ready",  idx, int'(guess_ready),  rdy);
  endtask

  task automatic drive(input int r, input int ld, input int sec, input int gv, input int g);
    rst         = (r != 0);
    load_secret = (ld != 0);
    secret_in   = 4'(sec);
    guess_valid = (gv != 0);
    guess_in    = 4'(g);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input int r, input int ld, input int sec, input int gv, input int g,
                     input int rv, input int hi, input int lo, input int tr,
                     input int w, input int l, input int e, input int rdy);
    vec_t v;
    v.rst = r; v.ld = ld; v.sec = sec; v.gv = gv; v.g = g;
    v.rv = rv; v.hi = hi; v.lo = lo; v.tr = tr; v.w = w; v.l = l; v.e = e; v.rdy = rdy;
    vecs.push_back(v);
  endtask

  initial begin
    force_bad = 1'b0;
    drive(1, 0, 0, 0, 0);

    //   rst ld sec gv  g   rv hi lo tr  w  l  e rdy
    add(1,  0, 0,  0, 0,   0, 0, 0, 0, 0, 0, 0, 0);   // reset state
    // secret 9, guess 9 -> win after two cycles
    add(0,  1, 9,  0, 0,   0, 0, 0, 0, 0, 0, 0, 1);
    add(0,  0, 0,  1, 9,   0, 0, 0, 0, 0, 0, 0, 0);
    add(0,  0, 0,  0, 0,   1, 0, 0, 1, 1, 0, 0, 0);
    add(0,  0, 0,  0, 0,   0, 0, 0, 1, 1, 0, 0, 0);
    add(0,  0, 0,  1, 3,   0, 0, 0, 1, 1, 0, 0, 0);   // ignored in WIN
    // secret 6, guesses 10, 2, 6
    add(0,  1, 6,  0, 0,   0, 0, 0, 0, 0, 0, 0, 1);
    add(0,  0, 0,  1, 10,  0, 0, 0, 0, 0, 0, 0, 0);
    add(0,  0, 0,  0, 0,   1, 1, 0, 1, 0, 0, 0, 1);
    add(0,  0, 0,  1, 2,   0, 1, 0, 1, 0, 0, 0, 0);
    add(0,  0, 0,  0, 0,   1, 0, 1, 2, 0, 0, 0, 1);
    add(0,  0, 0,  0, 0,   0, 0, 1, 2, 0, 0, 0, 1);   // hints hold
    add(0,  0, 0,  1, 6,   0, 0, 1, 2, 0, 0, 0, 0);
    add(0,  0, 0,  0, 0,   1, 0, 0, 3, 1, 0, 0, 0);
    // secret 3, guesses 0,1,2,4,5 -> lose at five tries
    add(0,  1, 3,  0, 0,   0, 0, 0, 0, 0, 0, 0, 1);
    add(0,  0, 0,  1, 0,   0, 0, 0, 0, 0, 0, 0, 0);
    add(0,  0, 0,  0, 0,   1, 0, 1, 1, 0, 0, 0, 1);
    add(0,  0, 0,  1, 1,   0, 0, 1, 1, 0, 0, 0, 0);
    add(0,  0, 0,  0, 0,   1, 0, 1, 2, 0, 0, 0, 1);
    add(0,  0, 0,  1, 2,   0, 0, 1, 2, 0, 0, 0, 0);
    add(0,  0, 0,  0, 0,   1, 0, 1, 3, 0, 0, 0, 1);
    add(0,  0, 0,  1, 4,   0, 0, 1, 3, 0, 0, 0, 0);
    add(0,  0, 0,  0, 0,   1, 1, 0, 4, 0, 0, 0, 1);
    add(0,  0, 0,  1, 5,   0, 1, 0, 4, 0, 0, 0, 0);
    add(0,  0, 0,  0, 0,   1, 1, 0, 5, 0, 1, 0, 0);
    add(0,  0, 0,  1, 3,   0, 1, 0, 5, 0, 1, 0, 0);   // sixth guess ignored
    add(0,  0, 0,  0, 0,   0, 1, 0, 5, 0, 1, 0, 0);
    // load_secret and guess_valid together in READY: guess dropped
    add(0,  1, 5,  0, 0,   0, 0, 0, 0, 0, 0, 0, 1);
    add(0,  1, 7,  1, 7,   0, 0, 0, 0, 0, 0, 0, 1);
    add(0,  0, 0,  0, 0,   0, 0, 0, 0, 0, 0, 0, 1);
    add(0,  0, 0,  1, 7,   0, 0, 0, 0, 0, 0, 0, 0);
    add(0,  0, 0,  0, 0,   1, 0, 0, 1, 1, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].ld, vecs[i].sec, vecs[i].gv, vecs[i].g);
      step();
      check_all(i, vecs[i].rv, vecs[i].hi, vecs[i].lo, vecs[i].tr,
                vecs[i].w, vecs[i].l, vecs[i].e, vecs[i].rdy);
    end

    // Malformed comparator flags: counted miss, sticky err, cleared by reload.
    drive(0, 1, 8, 0, 0);  step();
    check("cmp_b", 100, int'(cmp_b), 8);
    drive(0, 0, 0, 1, 8);  force_bad = 1'b1;  step();
    check("cmp_a", 101, int'(cmp_a), 8);
    drive(0, 0, 0, 0, 0);  step();
    force_bad = 1'b0;
    check_all(102, 1, 0, 0, 1, 0, 0, 1, 1);
    drive(0, 0, 0, 1, 2);  step();
    drive(0, 0, 0, 0, 0);  step();
    check_all(103, 1, 0, 1, 2, 0, 0, 1, 1);
    drive(0, 1, 8, 0, 0);  step();
    check_all(104, 0, 0, 0, 0, 0, 0, 0, 1);

    // load_secret during COMPARE discards the pending result.
    drive(0, 1, 2, 0, 0);  step();
    drive(0, 0, 0, 1, 5);  step();
    drive(0, 1, 5, 0, 0);  step();
    check_all(105, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 1, 5);  step();
    drive(0, 0, 0, 0, 0);  step();
    check_all(106, 1, 0, 0, 1, 1, 0, 0, 0);

    // Reset during COMPARE, then guesses ignored until a new secret.
    drive(0, 1, 4, 0, 0);  step();
    drive(0, 0, 0, 1, 1);  step();
    drive(1, 0, 0, 0, 0);  step();
    check_all(107, 0, 0, 0, 0, 0, 0, 0, 0);
    check("cmp_a", 107, int'(cmp_a), 0);
    check("cmp_b", 107, int'(cmp_b), 0);
    drive(0, 0, 0, 1, 4);  step();
    check_all(108, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);  step();
    check_all(109, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 4, 0, 0);  step();
    drive(0, 0, 0, 1, 4);  step();
    drive(0, 0, 0, 0, 0);  step();
    check_all(110, 1, 0, 0, 1, 1, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
